// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI definitions (state encoding, byte width, default fill byte) for slave and master.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int                    SPI_BYTE_W       = 8;
  localparam int                    SPI_CNT_W        = $clog2(SPI_BYTE_W);
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_DEFAULT = 8'h00;

  function automatic logic is_last_bit(input logic [SPI_CNT_W-1:0] cnt);
    return cnt == SPI_CNT_W'(SPI_BYTE_W - 1);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: STAGES-deep synchronizer for one asynchronous input, plus rise/fall detection
// against one further registered copy of the synchronized level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_level = r_chain[STAGES-1];
  assign o_rise  = r_chain[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_chain[STAGES-1] & r_prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave (MSB first) clocked by the system clock with synchronized SPI inputs.
// Transmit path is built only when SPI_SLAVE_TX_EN is defined; otherwise so/tx_ready/tx_underrun are 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] FILL_BYTE   = SPI_FILL_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  si,
  output logic                  so,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun
);
  localparam int                WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_si_level, w_si_rise_unused, w_si_fall_unused;
  logic w_start;

  spi_state_e             r_state;
  logic [SPI_CNT_W-1:0]   r_bit_cnt;
  logic [SPI_BYTE_W-2:0]  r_rx_shift;
  logic [SPI_BYTE_W-1:0]  r_rx_data;
  logic                   r_rx_valid;
  logic [WARM_W-1:0]      r_warm;
  logic                   r_armed;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .i_async(sck),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset), .i_async(cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_si (
    .clock(clock), .reset(reset), .i_async(si),
    .o_level(w_si_level), .o_rise(w_si_rise_unused), .o_fall(w_si_fall_unused)
  );

  // A cs_n fall only counts once the synchronizer holds real samples showing cs_n high,
  // so a select still held low across reset cannot restart a transfer.
  assign w_start = (r_state == IDLE) & w_cs_fall & r_armed;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_warm     <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_warm != WARM_DONE) begin
        r_warm <= r_warm + WARM_W'(1);
      end else if (w_cs_level) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= ACTIVE;
            r_bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
          end else if (w_sck_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_BYTE_W-3:0], w_si_level};
            r_bit_cnt  <= r_bit_cnt + SPI_CNT_W'(1);
            if (is_last_bit(r_bit_cnt)) begin
              r_rx_data  <= {r_rx_shift, w_si_level};
              r_rx_valid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_TX_EN
  logic [SPI_BYTE_W-1:0] r_hold;
  logic [SPI_BYTE_W-1:0] r_tx_shift;
  logic                  r_hold_full;
  logic                  r_underrun;
  logic                  w_reload;

  assign w_reload = w_start |
                    ((r_state == ACTIVE) & ~w_cs_rise & w_sck_fall & (r_bit_cnt == '0));

  // A reload sees only what was queued before this cycle; a byte accepted now waits for the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_shift  <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_reload) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift <= FILL_BYTE;
          r_underrun <= 1'b1;
        end
      end else if ((r_state == ACTIVE) & w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
      end
      if (tx_valid & ~r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign so          = (r_state == ACTIVE) & r_tx_shift[SPI_BYTE_W-1];
  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_underrun;
`else
  logic w_unused_tx;
  assign w_unused_tx = ^{tx_data, tx_valid, FILL_BYTE, w_sck_fall};
  assign so          = 1'b0;
  assign tx_ready    = 1'b0;
  assign tx_underrun = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI master driving spi_slave; a byte-level reference model feeds
// expectation queues that independent monitors pop when the DUT presents rx bytes or so bytes.
`timescale 1ns/1ps
module tb_spi_slave;
`ifdef SPI_SLAVE_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif
  localparam logic [7:0] FILL = 8'h00;
  localparam int         HALF = 6;

  logic       clock = 1'b0;
  logic       reset, sck, cs_n, si, so;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, tx_valid, tx_ready, tx_underrun;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_so[$];
  logic [7:0] m_hold;
  bit         m_hold_full = 1'b0;
  logic [7:0] m_cur;
  int         exp_underrun = 0;
  int         obs_underrun = 0;
  int         rx_pulses = 0;
  bit         so_mon_en = 1'b0;
  int         so_bits = 0;
  logic [7:0] so_acc;
  int         p0;

  always #5 clock = ~clock;

  spi_slave dut (
    .clock(clock), .reset(reset), .sck(sck), .cs_n(cs_n), .si(si), .so(so),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Next byte the slave must present: queued byte if any, else the fill byte with an underrun.
  function automatic logic [7:0] load_next();
    if (!TX_EN) return 8'h00;
    if (m_hold_full) begin
      m_hold_full = 1'b0;
      return m_hold;
    end
    exp_underrun++;
    return FILL;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic offer(input logic [7:0] b);
    check("tx_ready", tx_ready, TX_EN && !m_hold_full);
    tx_data  = b;
    tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
    if (TX_EN && !m_hold_full) begin
      m_hold      = b;
      m_hold_full = 1'b1;
    end
  endtask

  task automatic xfer(input int nbytes, input int cut, input int first,
                      input bit mid_en, input logic [7:0] mid_val);
    int         rises;
    int         total;
    logic [7:0] d;
    rises     = 0;
    total     = (cut < 0) ? nbytes * 8 : cut;
    so_bits   = 0;
    so_mon_en = 1'b1;
    cs_n      = 1'b0;
    m_cur     = load_next();
    clks(2 * HALF);
    check("underrun_at_start", obs_underrun, exp_underrun);
    for (int b = 0; b < nbytes && rises < total; b++) begin
      d = (b == 0 && first >= 0) ? first[7:0] : 8'($urandom);
      if (total - rises >= 8) begin
        exp_so.push_back(m_cur);
        exp_rx.push_back(d);
      end
      for (int i = 7; i >= 0 && rises < total; i--) begin
        si = d[i];
        clks(HALF);
        sck = 1'b1;
        rises++;
        clks(HALF);
        sck = 1'b0;
        if (mid_en && b == 0 && i == 4) offer(mid_val);
        if (i == 0) m_cur = load_next();
      end
    end
    clks(HALF);
    cs_n = 1'b1;
    clks(2 * HALF);
    so_mon_en = 1'b0;
    check("underrun_end", obs_underrun, exp_underrun);
    check("so_idle", so, 1'b0);
  endtask

  // rx / underrun monitor
  always @(posedge clock) begin
    #1;
    if (reset === 1'b0) begin
      if (tx_underrun === 1'b1) obs_underrun++;
      if (rx_valid === 1'b1) begin
        rx_pulses++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: rx_valid pulse with rx_data %0h, expected no pulse", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx.pop_front());
        end
      end
    end
  end

  // so monitor: assemble the byte the master sees on its sampling edges
  always @(posedge sck) begin
    if (so_mon_en) begin
      so_acc = {so_acc[6:0], so};
      so_bits++;
      if (so_bits == 8) begin
        so_bits = 0;
        if (exp_so.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL so_unexpected: so byte %0h, expected none", so_acc);
        end else begin
          check("so_byte", so_acc, exp_so.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; si = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    clks(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_so", so, 1'b0);
    check("rst_underrun", tx_underrun, 1'b0);
    check("rst_tx_ready", tx_ready, TX_EN);
    reset = 1'b0;
    clks(10);

    // queued A5 out, 3C in
    p0 = rx_pulses;
    offer(8'hA5);
    xfer(1, -1, 8'h3C, 1'b0, 8'h00);
    check("rx_pulses_1byte", rx_pulses - p0, 1);

    // nothing queued: fill byte and underrun
    xfer(1, -1, -1, 1'b0, 8'h00);

    // two-byte transfer, second byte queued during the first
    p0 = rx_pulses;
    offer(8'h11);
    xfer(2, -1, -1, 1'b1, 8'h22);
    check("rx_pulses_2byte", rx_pulses - p0, 2);

    // abort after 5 rises, then a clean transfer
    p0 = rx_pulses;
    xfer(1, 5, -1, 1'b0, 8'h00);
    check("rx_pulses_abort", rx_pulses - p0, 0);
    xfer(1, -1, -1, 1'b0, 8'h00);

    // reset mid-byte with cs_n held low
    offer(8'h77);
    so_mon_en = 1'b0;
    cs_n = 1'b0;
    m_cur = load_next();
    clks(2 * HALF);
    for (int i = 0; i < 3; i++) begin
      si = 1'($urandom); clks(HALF); sck = 1'b1; clks(HALF); sck = 1'b0;
    end
    clks(2);
    reset = 1'b1;
    clks(1);
    m_hold_full = 1'b0;
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_so", so, 1'b0);
    check("mid_rst_underrun", tx_underrun, 1'b0);
    check("mid_rst_tx_ready", tx_ready, TX_EN);
    reset = 1'b0;
    p0 = obs_underrun;
    for (int i = 0; i < 10; i++) begin
      si = 1'($urandom); clks(HALF); sck = 1'b1; clks(HALF);
      check("so_ignored", so, 1'b0);
      sck = 1'b0;
    end
    clks(HALF);
    check("rx_data_after_ignored", rx_data, 8'h00);
    check("underrun_after_ignored", obs_underrun - p0, 0);
    cs_n = 1'b1;
    clks(2 * HALF);
    xfer(1, -1, -1, 1'b0, 8'h00);

    // randomized transfers
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      xfer($urandom_range(1, 3),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1,
           -1, 1'($urandom), 8'($urandom));
      clks($urandom_range(2, 10));
    end

    clks(20);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("so_queue_drained", exp_so.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
